// File: rtl/cmd_physical_pkg.sv
// Shared definitions for the SD CMD-line engine: states, frame geometry, CRC7 step.
// Purely combinational helpers; no timing or backpressure of its own.
package cmd_physical_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_RESP,
    RECEIVE,
    HANDOFF,
    TIMEOUT
  } state_e;

  localparam int FRAME_W       = 48;
  localparam int CMD_W         = 38;
  localparam int CRC_W         = 7;
  localparam int HDR_W         = FRAME_W - CRC_W - 1;
  localparam int START_BIT_POS = 47;
  localparam int TX_BIT_POS    = 46;
  localparam logic [CRC_W-1:0] CRC7_POLY = 7'h09;

  // Header bits [47:8] of a command frame, returned right-aligned.
  function automatic logic [HDR_W-1:0] make_hdr(input logic [CMD_W-1:0] cmd);
    logic [HDR_W-1:0] h;
    h = {2'b00, cmd};
    h[START_BIT_POS-CRC_W-1] = 1'b0;
    h[TX_BIT_POS-CRC_W-1]    = 1'b1;
    return h;
  endfunction

  function automatic logic [CRC_W-1:0] crc7_step(input logic [CRC_W-1:0] c, input logic b);
    logic fb;
    fb = b ^ c[CRC_W-1];
    return {c[CRC_W-2:0], 1'b0} ^ (fb ? CRC7_POLY : {CRC_W{1'b0}});
  endfunction

endpackage

// File: rtl/cmd_physical_if.sv
// Master-stage and CMD-pin signals of cmd_physical; the master modport is the requester side.
interface cmd_physical_if;
  logic        REQ_in;
  logic        ACK_in;
  logic [37:0] cmd_to_physical;
  logic        cmd_pin_in;
  logic        cmd_pin_out;
  logic        cmd_pin_oe;
  logic        ACK_out;
  logic        REQ_out;
  logic [47:0] cmd_response;
  logic        timeout_error;
  logic        crc_error;
  logic        physical_inactive;

  modport master (
    output REQ_in, ACK_in, cmd_to_physical, cmd_pin_in,
    input  cmd_pin_out, cmd_pin_oe, ACK_out, REQ_out, cmd_response,
           timeout_error, crc_error, physical_inactive
  );

  modport slave (
    input  REQ_in, ACK_in, cmd_to_physical, cmd_pin_in,
    output cmd_pin_out, cmd_pin_oe, ACK_out, REQ_out, cmd_response,
           timeout_error, crc_error, physical_inactive
  );
endinterface

// File: rtl/cmd_physical_crc7_serial.sv
// Serial CRC7 (x^7+x^3+1), one bit per enabled clock; result valid the cycle after the last bit.
// No backpressure: clear wins over enable.
module crc7_serial
  import cmd_physical_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc
);

  logic [CRC_W-1:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = '0;
    end else if (enable) begin
      crc_d = crc7_step(crc_q, bit_in);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/cmd_physical.sv
// SD CMD-line engine: 48-bit command out, 48-bit response in, REQ/ACK handoff to the master (held until ACK_in or REQ_in drop).
// Optional CMD_PHY_RESP_CRC_CHECK_EN adds response CRC7 checking; otherwise crc_error is tied low.
module cmd_physical
  import cmd_physical_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic           CLK_SD_card,
  input  logic           reset,
  cmd_physical_if.slave  bus
);

  localparam logic [6:0] TO_LIM = 7'(TIMEOUT_CYCLES);

  state_e               state_q, state_d;
  logic [5:0]           bit_cnt_q, bit_cnt_d;
  logic [6:0]           wait_cnt_q, wait_cnt_d;
  logic [HDR_W-1:0]     tx_shift_q, tx_shift_d;
  logic [FRAME_W-2:0]   rx_shift_q, rx_shift_d;
  logic [FRAME_W-1:0]   resp_q, resp_d;

  logic [CRC_W-1:0]     tx_crc;
  logic                 tx_crc_clr, tx_crc_en;
  logic [5:0]           tx_pos;
  logic [2:0]           crc_sel;
  logic                 pin_out;
  logic [6:0]           wait_inc;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    wait_cnt_d = wait_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    resp_d     = resp_q;
    tx_crc_clr = 1'b0;
    tx_crc_en  = 1'b0;
    pin_out    = 1'b1;
    tx_pos     = 6'(START_BIT_POS) - bit_cnt_q;
    crc_sel    = 3'(tx_pos - 6'd1);
    wait_inc   = wait_cnt_q + 7'd1;

    case (state_q)
      IDLE: begin
        if (bus.REQ_in) state_d = LOAD;
      end
      LOAD: begin
        tx_shift_d = make_hdr(bus.cmd_to_physical);
        bit_cnt_d  = '0;
        wait_cnt_d = '0;
        tx_crc_clr = 1'b1;
        state_d    = SEND;
      end
      SEND: begin
        // Bit position walks 47..0: header from the shifter, then CRC, then end bit.
        if (tx_pos > 6'(CRC_W)) begin
          pin_out    = tx_shift_q[HDR_W-1];
          tx_shift_d = {tx_shift_q[HDR_W-2:0], 1'b0};
          tx_crc_en  = 1'b1;
        end else if (tx_pos != 6'd0) begin
          pin_out = tx_crc[crc_sel];
        end
        bit_cnt_d = bit_cnt_q + 6'd1;
        if (bit_cnt_q == 6'(FRAME_W-1)) begin
          bit_cnt_d  = '0;
          wait_cnt_d = 7'd1;
          state_d    = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        wait_cnt_d = wait_inc;
        if (!bus.cmd_pin_in) begin
          rx_shift_d = {{(FRAME_W-2){1'b0}}, bus.cmd_pin_in};
          bit_cnt_d  = '0;
          wait_cnt_d = '0;
          state_d    = RECEIVE;
        end else if (wait_inc == TO_LIM) begin
          wait_cnt_d = '0;
          state_d    = TIMEOUT;
        end
      end
      RECEIVE: begin
        rx_shift_d = {rx_shift_q[FRAME_W-3:0], bus.cmd_pin_in};
        bit_cnt_d  = bit_cnt_q + 6'd1;
        if (bit_cnt_q == 6'(FRAME_W-2)) begin
          resp_d    = {rx_shift_q, bus.cmd_pin_in};
          bit_cnt_d = '0;
          state_d   = HANDOFF;
        end
      end
      HANDOFF: begin
        if (bus.ACK_in || !bus.REQ_in) state_d = IDLE;
      end
      TIMEOUT: begin
        if (!bus.REQ_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_SD_card) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      wait_cnt_q <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      resp_q     <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      resp_q     <= resp_d;
    end
  end

  crc7_serial u_tx_crc (
    .clk    (CLK_SD_card),
    .rst    (reset),
    .clear  (tx_crc_clr),
    .enable (tx_crc_en),
    .bit_in (tx_shift_q[HDR_W-1]),
    .crc    (tx_crc)
  );

`ifdef CMD_PHY_RESP_CRC_CHECK_EN
  logic [CRC_W-1:0] rx_crc;
  logic             rx_crc_clr, rx_crc_en;
  logic             crc_error_q, crc_error_d;

  // Covers the start bit seen in WAIT_RESP plus the next 39 bits, i.e. [47:8].
  always_comb begin
    rx_crc_clr  = (state_q == LOAD);
    rx_crc_en   = ((state_q == WAIT_RESP) && !bus.cmd_pin_in) ||
                  ((state_q == RECEIVE) && (bit_cnt_q < 6'(HDR_W-1)));
    crc_error_d = crc_error_q;
    if (state_d == IDLE) begin
      crc_error_d = 1'b0;
    end else if ((state_q == RECEIVE) && (bit_cnt_q == 6'(FRAME_W-2))) begin
      crc_error_d = (rx_crc != rx_shift_q[CRC_W-1:0]);
    end
  end

  always_ff @(posedge CLK_SD_card) begin
    if (reset) begin
      crc_error_q <= 1'b0;
    end else begin
      crc_error_q <= crc_error_d;
    end
  end

  crc7_serial u_rx_crc (
    .clk    (CLK_SD_card),
    .rst    (reset),
    .clear  (rx_crc_clr),
    .enable (rx_crc_en),
    .bit_in (bus.cmd_pin_in),
    .crc    (rx_crc)
  );

  assign bus.crc_error = crc_error_q;
`else
  assign bus.crc_error = 1'b0;
`endif

  assign bus.cmd_pin_out       = pin_out;
  assign bus.cmd_pin_oe        = (state_q == SEND);
  assign bus.ACK_out           = (state_q == SEND) || (state_q == WAIT_RESP) || (state_q == RECEIVE);
  assign bus.REQ_out           = (state_q == HANDOFF);
  assign bus.timeout_error     = (state_q == TIMEOUT);
  assign bus.physical_inactive = (state_q == IDLE);
  assign bus.cmd_response      = resp_q;

endmodule

// File: tb/tb_cmd_physical.sv
// Directed bench for cmd_physical: frame encoding, response capture, timeout, abandon and reset paths.
module tb_cmd_physical;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [47:0] frame;

`ifdef CMD_PHY_RESP_CRC_CHECK_EN
  localparam logic EXP_BAD_CRC = 1'b1;
`else
  localparam logic EXP_BAD_CRC = 1'b0;
`endif

  cmd_physical_if bus ();

  cmd_physical #(.TIMEOUT_CYCLES(64)) dut (
    .CLK_SD_card (clk),
    .reset       (reset),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise REQ_in and wait (bounded) for the first driven frame bit.
  task automatic start_cmd(input logic [37:0] cmd);
    int n;
    n = 0;
    bus.cmd_to_physical = cmd;
    bus.REQ_in = 1'b1;
    while (!bus.cmd_pin_oe && n < 10) begin
      tick();
      n++;
    end
    check_eq("oe_first_bit", 48'(bus.cmd_pin_oe), 48'd1);
    check_eq("ack_first_bit", 48'(bus.ACK_out), 48'd1);
  endtask

  // Collects the 48 line bits; returns in the end-bit cycle.
  task automatic capture_frame(input int drop_req_at, output logic [47:0] f);
    f = '0;
    for (int i = 0; i < 48; i++) begin
      f = {f[46:0], bus.cmd_pin_out};
      if (i == drop_req_at) bus.REQ_in = 1'b0;
      if (i < 47) tick();
    end
  endtask

  task automatic send_resp(input logic [47:0] r);
    for (int i = 0; i < 48; i++) begin
      bus.cmd_pin_in = r[47-i];
      tick();
    end
    bus.cmd_pin_in = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.REQ_in = 1'b0;
    bus.ACK_in = 1'b0;
    bus.cmd_to_physical = '0;
    bus.cmd_pin_in = 1'b1;
    tick();
    tick();
    check_eq("rst_pin_out", 48'(bus.cmd_pin_out), 48'd1);
    check_eq("rst_pin_oe", 48'(bus.cmd_pin_oe), 48'd0);
    check_eq("rst_ack_out", 48'(bus.ACK_out), 48'd0);
    check_eq("rst_req_out", 48'(bus.REQ_out), 48'd0);
    check_eq("rst_timeout", 48'(bus.timeout_error), 48'd0);
    check_eq("rst_crc_err", 48'(bus.crc_error), 48'd0);
    check_eq("rst_response", bus.cmd_response, 48'h0);
    check_eq("rst_inactive", 48'(bus.physical_inactive), 48'd1);
    reset = 1'b0;
    tick();

    // CMD0 out, good response back 5 cycles after the end bit, acked.
    start_cmd({6'd0, 32'h0});
    capture_frame(-1, frame);
    check_eq("cmd0_frame", frame, 48'h400000000095);
    tick();
    check_eq("wait_ack_out", 48'(bus.ACK_out), 48'd1);
    check_eq("wait_pin_oe", 48'(bus.cmd_pin_oe), 48'd0);
    repeat (4) tick();
    send_resp(48'h400000000095);
    check_eq("resp_req_out", 48'(bus.REQ_out), 48'd1);
    check_eq("resp_value", bus.cmd_response, 48'h400000000095);
    check_eq("resp_crc_ok", 48'(bus.crc_error), 48'd0);
    check_eq("handoff_ack_out", 48'(bus.ACK_out), 48'd0);
    bus.ACK_in = 1'b1;
    tick();
    bus.ACK_in = 1'b0;
    bus.REQ_in = 1'b0;
    check_eq("ack_to_idle", 48'(bus.physical_inactive), 48'd1);
    check_eq("ack_req_out", 48'(bus.REQ_out), 48'd0);
    tick();

    // CMD8 out, line left high: timeout 64 cycles after the end bit.
    start_cmd({6'd8, 32'h000001AA});
    capture_frame(-1, frame);
    check_eq("cmd8_frame", frame, 48'h48000001AA87);
    repeat (63) tick();
    check_eq("to_not_yet", 48'(bus.timeout_error), 48'd0);
    check_eq("to_wait_ack", 48'(bus.ACK_out), 48'd1);
    tick();
    check_eq("to_asserted", 48'(bus.timeout_error), 48'd1);
    check_eq("to_req_out", 48'(bus.REQ_out), 48'd0);
    check_eq("to_resp_held", bus.cmd_response, 48'h400000000095);
    bus.REQ_in = 1'b0;
    tick();
    check_eq("to_exit_idle", 48'(bus.physical_inactive), 48'd1);
    check_eq("to_cleared", 48'(bus.timeout_error), 48'd0);
    tick();

    // REQ_in dropped mid-SEND; bad-CRC response; abandon from HANDOFF.
    start_cmd({6'd0, 32'h0});
    capture_frame(10, frame);
    check_eq("drop_req_frame", frame, 48'h400000000095);
    repeat (5) tick();
    send_resp(48'h400000000097);
    check_eq("bad_req_out", 48'(bus.REQ_out), 48'd1);
    check_eq("bad_resp_value", bus.cmd_response, 48'h400000000097);
    check_eq("bad_crc_flag", 48'(bus.crc_error), 48'(EXP_BAD_CRC));
    tick();
    check_eq("abandon_idle", 48'(bus.physical_inactive), 48'd1);
    check_eq("abandon_req_out", 48'(bus.REQ_out), 48'd0);
    check_eq("abandon_crc_clr", 48'(bus.crc_error), 48'd0);
    tick();

    // Reset at SEND bit 20.
    start_cmd({6'd0, 32'h0});
    repeat (20) tick();
    reset = 1'b1;
    bus.REQ_in = 1'b0;
    tick();
    check_eq("midrst_pin_oe", 48'(bus.cmd_pin_oe), 48'd0);
    check_eq("midrst_pin_out", 48'(bus.cmd_pin_out), 48'd1);
    check_eq("midrst_ack_out", 48'(bus.ACK_out), 48'd0);
    check_eq("midrst_inactive", 48'(bus.physical_inactive), 48'd1);
    check_eq("midrst_response", bus.cmd_response, 48'h0);
    reset = 1'b0;
    tick();
    check_eq("post_rst_idle", 48'(bus.physical_inactive), 48'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_physical.md
CMD_PHYSICAL -- requirements
Module: cmd_physical

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: maximum number of clocks from the end bit to the response start bit.
REQ-002 CLK_SD_card  input  1  SD card clock; the only clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 REQ_in  input  1  command request from the master stage.
REQ-005 ACK_in  input  1  master acknowledge of a delivered response.
REQ-006 cmd_to_physical  input  38  [37:32] command index, [31:0] argument.
REQ-007 cmd_pin_in  input  1  sampled CMD line.
REQ-008 cmd_pin_out  output  1  driven CMD line value.
REQ-009 cmd_pin_oe  output  1  CMD line output enable.
REQ-010 ACK_out  output  1  command accepted and in progress.
REQ-011 REQ_out  output  1  response valid, awaiting ACK_in.
REQ-012 cmd_response  output  48  last received response frame, bit 47 first on the line.
REQ-013 timeout_error  output  1  no start bit seen within TIMEOUT_CYCLES.
REQ-014 crc_error  output  1  response CRC7 mismatch.
REQ-015 physical_inactive  output  1  block is idle.
REQ-016 All inputs are already synchronous to CLK_SD_card.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, SEND, WAIT_RESP, RECEIVE, HANDOFF and TIMEOUT.
REQ-018 IDLE: physical_inactive=1, cmd_pin_oe=0, cmd_pin_out=1; REQ_in=1 -> LOAD.
REQ-019 LOAD (1 cycle): latch cmd_to_physical; build frame {0,1,index,arg}; clear CRC and bit counter -> SEND.
REQ-020 SEND (48 cycles): cmd_pin_oe=1; drive one bit per clock, MSB first: 40 header/argument bits, then 7 CRC bits, then end bit 1 -> WAIT_RESP.
REQ-021 CRC7 uses x^7+x^3+1, initial value 0, computed serially over the first 40 frame bits.
REQ-022 ACK_out SHALL be 1 in SEND, WAIT_RESP and RECEIVE, and 0 otherwise.
REQ-023 WAIT_RESP: cmd_pin_oe=0; a 7-bit counter increments each cycle. cmd_pin_in=0 -> RECEIVE with that bit stored as bit 47. Counter reaching TIMEOUT_CYCLES with no start bit -> TIMEOUT.
REQ-024 RECEIVE: shift the remaining 47 bits; after bit 0 is shifted in, update cmd_response -> HANDOFF.
REQ-025 HANDOFF: REQ_out=1; cmd_response held stable. ACK_in=1 -> IDLE; REQ_in=0 -> IDLE (master abandoned the transfer).
REQ-026 TIMEOUT: timeout_error=1 and REQ_out=0; REQ_in=0 -> IDLE.
REQ-027 cmd_response SHALL hold its value until the next completed RECEIVE.
REQ-028 REQ_in deasserting during SEND, WAIT_RESP or RECEIVE SHALL be ignored; the frame completes.
REQ-029 A new REQ_in is accepted no earlier than the first cycle after IDLE is entered (no back-to-back skip of IDLE).

Reset
REQ-030 Reset in any state, including mid-SEND, SHALL on the next edge return the block to IDLE and release the line.
REQ-031 Reset values: cmd_pin_out=1, cmd_pin_oe=0, ACK_out=0, REQ_out=0, timeout_error=0, crc_error=0, cmd_response=0, physical_inactive=1; all counters 0.

Configuration
REQ-032 CMD_PHY_RESP_CRC_CHECK_EN defined: the block computes CRC7 over response bits [47:8] and compares it to [7:1]. On a mismatch, crc_error=1 in HANDOFF until IDLE.
REQ-033 CMD_PHY_RESP_CRC_CHECK_EN undefined: crc_error is tied 0 and no response-CRC logic exists.

Structure
REQ-034 A shared package holds the state encodings, the frame width of 48, the start and transmission bit positions, and the CRC7 polynomial constant.
REQ-035 A serial CRC7 sub-module, crc7_serial (inputs: clear, enable, bit in; output: 7-bit CRC), is instantiated once for transmit and, under the macro, once for receive.

Verification
REQ-036 cmd_to_physical={6'd0,32'h0} with REQ_in=1 -> the line carries 48'h400000000095 over 48 cycles; ACK_out=1 from the first frame bit.
REQ-037 Index 8, argument 32'h000001AA -> the line carries 48'h48000001AA87.
REQ-038 Bench drives 48'h400000000095 back 5 cycles after the end bit -> REQ_out=1, cmd_response=48'h400000000095, crc_error=0; ACK_in=1 -> IDLE next cycle.
REQ-039 With the macro defined, the bench drives 48'h400000000097 -> crc_error=1 in HANDOFF.
REQ-040 Line held 1 after the end bit -> timeout_error=1 exactly 64 cycles after the end bit; REQ_in=0 -> IDLE and timeout_error=0.
REQ-041 Reset asserted at SEND bit 20 -> the next edge gives cmd_pin_oe=0, cmd_pin_out=1, ACK_out=0, physical_inactive=1.
